// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter
//   Shares one SDRAM port between a game loader, the CPU and the PPU using a
//   4-cycle slot scheme. A new owner is chosen on the edge that closes a
//   phase==3 cycle. That command is then held for the following four cycles.
//   Loader writes are queued in a small FIFO and always win a slot. CPU and
//   PPU requests are latched, so single-cycle pulses are never lost. A starve
//   bit makes sure the PPU is never passed over twice in a row by the CPU.
//
// Ports
//   clk, reset          : clock; asynchronous active-high reset
//   phase[1:0]          : free-running slot counter
//   downloading         : game download in progress (CPU/PPU held off)
//   ldr_wr/addr/data    : loader write strobe, address, data
//   cpu_rd/wr/addr/dout : CPU request strobes, address, write data
//   ppu_rd/addr         : PPU read strobe and address
//   mem_addr/din/we/oe_a/oe_b : registered SDRAM command
//   grant[1:0]          : slot owner (0 idle, 1 loader, 2 CPU, 3 PPU)
//   fifo_full, busy     : loader FIFO full / non-empty
//   overflow            : sticky, set when a loader write was dropped
module sdram_slot_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        phase,
    input  logic              downloading,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              ppu_rd,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_oe_a,
    output logic              mem_oe_b,
    output logic [1:0]        grant,
    output logic              fifo_full,
    output logic              busy,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LDR  = 2'd1,
        ST_CPU  = 2'd2,
        ST_PPU  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d, mem_oe_a_q, mem_oe_a_d, mem_oe_b_q, mem_oe_b_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d, starve_q, starve_d;
    logic              cpu_rd_pend_q, cpu_rd_pend_d, cpu_wr_pend_q, cpu_wr_pend_d;
    logic              ppu_pend_q, ppu_pend_d;
    logic [ADDR_W-1:0] cpu_rd_addr_q, cpu_rd_addr_d, cpu_wr_addr_q, cpu_wr_addr_d;
    logic [ADDR_W-1:0] ppu_addr_q, ppu_addr_d;
    logic [7:0]        cpu_wr_data_q, cpu_wr_data_d;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]  fifo_head;
    logic              slot, fifo_nonempty, full, pop, push, drop;
    logic              take_rd, take_wr, take_ppu;
    // Registered flag OR this cycle's strobe: a request arriving in the
    // phase==3 cycle itself still competes for the slot starting next cycle.
    logic              cpu_rd_eff, cpu_wr_eff, ppu_eff;
    logic [ADDR_W-1:0] cpu_rd_addr_eff, cpu_wr_addr_eff, ppu_addr_eff;
    logic [7:0]        cpu_wr_data_eff;

    // FIFO storage is not reset; only the pointers and count are.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                fifo_mem[gi] <= {ldr_addr, ldr_data};
            end
        end
    end

    assign fifo_head       = fifo_mem[rd_ptr_q];
    assign slot            = (phase == 2'd3);
    assign fifo_nonempty   = (count_q != '0);
    assign full            = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop             = slot && fifo_nonempty;
    // The pop is evaluated first, so a push into a full FIFO is accepted
    // when an entry leaves on the same edge.
    assign push            = ldr_wr && (!full || pop);
    assign drop            = ldr_wr && full && !pop;

    assign cpu_rd_eff      = cpu_rd_pend_q | cpu_rd;
    assign cpu_wr_eff      = cpu_wr_pend_q | cpu_wr;
    assign ppu_eff         = ppu_pend_q | ppu_rd;
    assign cpu_rd_addr_eff = cpu_rd ? cpu_addr : cpu_rd_addr_q;
    assign cpu_wr_addr_eff = cpu_wr ? cpu_addr : cpu_wr_addr_q;
    assign cpu_wr_data_eff = cpu_wr ? cpu_dout : cpu_wr_data_q;
    assign ppu_addr_eff    = ppu_rd ? ppu_addr : ppu_addr_q;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = mem_we_q;
        mem_oe_a_d = mem_oe_a_q;
        mem_oe_b_d = mem_oe_b_q;
        take_rd    = 1'b0;
        take_wr    = 1'b0;
        take_ppu   = 1'b0;
        if (slot) begin
            mem_we_d   = 1'b0;
            mem_oe_a_d = 1'b0;
            mem_oe_b_d = 1'b0;
            if (fifo_nonempty) begin
                state_d    = ST_LDR;
                mem_addr_d = fifo_head[ENT_W-1:8];
                mem_din_d  = fifo_head[7:0];
                mem_we_d   = 1'b1;
            end else if (downloading) begin
                state_d = ST_IDLE;
            end else if (starve_q && ppu_eff) begin
                state_d    = ST_PPU;
                mem_addr_d = ppu_addr_eff;
                mem_oe_b_d = 1'b1;
                take_ppu   = 1'b1;
            end else if (cpu_wr_eff) begin
                state_d    = ST_CPU;
                mem_addr_d = cpu_wr_addr_eff;
                mem_din_d  = cpu_wr_data_eff;
                mem_we_d   = 1'b1;
                take_wr    = 1'b1;
            end else if (cpu_rd_eff) begin
                state_d    = ST_CPU;
                mem_addr_d = cpu_rd_addr_eff;
                mem_oe_a_d = 1'b1;
                take_rd    = 1'b1;
            end else if (ppu_eff) begin
                state_d    = ST_PPU;
                mem_addr_d = ppu_addr_eff;
                mem_oe_b_d = 1'b1;
                take_ppu   = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d    = overflow_q | drop;
        cpu_rd_pend_d = take_rd ? 1'b0 : cpu_rd_eff;
        cpu_wr_pend_d = take_wr ? 1'b0 : cpu_wr_eff;
        ppu_pend_d    = take_ppu ? 1'b0 : ppu_eff;
        cpu_rd_addr_d = cpu_rd_addr_eff;
        cpu_wr_addr_d = cpu_wr_addr_eff;
        cpu_wr_data_d = cpu_wr_data_eff;
        ppu_addr_d    = ppu_addr_eff;
        starve_d      = starve_q;
        if (take_ppu) begin
            starve_d = 1'b0;
        end else if ((take_rd || take_wr) && ppu_eff) begin
            starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_oe_a_q    <= 1'b0;
            mem_oe_b_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            starve_q      <= 1'b0;
            cpu_rd_pend_q <= 1'b0;
            cpu_wr_pend_q <= 1'b0;
            ppu_pend_q    <= 1'b0;
            cpu_rd_addr_q <= '0;
            cpu_wr_addr_q <= '0;
            cpu_wr_data_q <= '0;
            ppu_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_oe_a_q    <= mem_oe_a_d;
            mem_oe_b_q    <= mem_oe_b_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            starve_q      <= starve_d;
            cpu_rd_pend_q <= cpu_rd_pend_d;
            cpu_wr_pend_q <= cpu_wr_pend_d;
            ppu_pend_q    <= ppu_pend_d;
            cpu_rd_addr_q <= cpu_rd_addr_d;
            cpu_wr_addr_q <= cpu_wr_addr_d;
            cpu_wr_data_q <= cpu_wr_data_d;
            ppu_addr_q    <= ppu_addr_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign mem_oe_a  = mem_oe_a_q;
    assign mem_oe_b  = mem_oe_b_q;
    assign grant     = state_q;
    assign fifo_full = full;
    assign busy      = fifo_nonempty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter. Outputs are sampled on the falling
// edge. The observation vector is
//   {grant, mem_we, mem_oe_a, mem_oe_b, mem_addr, mem_din, busy, fifo_full, overflow}.
module tb_sdram_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  phase = 2'd0;
    logic        phase_run = 1'b1;
    logic        downloading = 1'b0;
    logic        ldr_wr = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, ppu_rd = 1'b0;
    logic [21:0] ldr_addr = '0, cpu_addr = '0, ppu_addr = '0;
    logic [7:0]  ldr_data = '0, cpu_dout = '0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_oe_a, mem_oe_b, fifo_full, busy, overflow;
    logic [1:0]  grant;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [37:0] exp_v;

    sdram_slot_arbiter dut (
        .clk(clk), .reset(reset), .phase(phase), .downloading(downloading),
        .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_oe_a(mem_oe_a), .mem_oe_b(mem_oe_b), .grant(grant),
        .fifo_full(fifo_full), .busy(busy), .overflow(overflow)
    );

    wire [37:0] obs = {grant, mem_we, mem_oe_a, mem_oe_b, mem_addr, mem_din, busy, fifo_full, overflow};

    always #5 clk = ~clk;

    // Free-running slot counter; the bench may freeze it to pack writes
    // between phase==3 cycles.
    always @(posedge clk) if (phase_run) phase <= phase + 2'd1;

    // Advance to the next falling edge in a phase-0 cycle (first cycle of a slot).
    task automatic next_slot;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase != 2'd0 && n < 8);
    endtask

    task automatic to_phase3;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase != 2'd3 && n < 8);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        exp_v = '0; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state got=%h want=%h", obs, exp_v); end
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_loader_burst;
        downloading = 1'b1;
        next_slot();
        ldr_wr = 1'b1; ldr_addr = 22'h10; ldr_data = 8'hA0; @(negedge clk);
        ldr_addr = 22'h11; ldr_data = 8'hA1; @(negedge clk);
        ldr_addr = 22'h12; ldr_data = 8'hA2; @(negedge clk);
        ldr_wr = 1'b0;
        next_slot();
        exp_v = {2'd1, 3'b100, 22'h10, 8'hA0, 3'b100}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ldr_slot0 got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd1, 3'b100, 22'h11, 8'hA1, 3'b100}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ldr_slot1 got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd1, 3'b100, 22'h12, 8'hA2, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ldr_slot2 got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd0, 3'b000, 22'h12, 8'hA2, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ldr_idle got=%h want=%h", obs, exp_v); end
        $display("[TB] loader burst done");
    endtask

    task automatic test_fifo_overflow;
        // Phase is frozen at 0, so nothing pops while the FIFO fills.
        phase_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ldr_wr = 1'b1; ldr_addr = 22'h20 + 22'(i); ldr_data = 8'hB0 + 8'(i);
            @(negedge clk);
        end
        ldr_wr = 1'b0;
        exp_v = {2'd0, 3'b000, 22'h12, 8'hA2, 3'b110}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL fifo_fill got=%h want=%h", obs, exp_v); end
        phase_run = 1'b1;
        to_phase3();
        // Push into a full FIFO on the pop edge: it must be accepted.
        ldr_wr = 1'b1; ldr_addr = 22'h24; ldr_data = 8'hB4;
        @(negedge clk);
        ldr_wr = 1'b0;
        exp_v = {2'd1, 3'b100, 22'h20, 8'hB0, 3'b110}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL push_pop_full got=%h want=%h", obs, exp_v); end
        phase_run = 1'b0;
        ldr_wr = 1'b1; ldr_addr = 22'h25; ldr_data = 8'hB5;
        @(negedge clk);
        ldr_wr = 1'b0;
        exp_v = {2'd1, 3'b100, 22'h20, 8'hB0, 3'b111}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL overflow_drop got=%h want=%h", obs, exp_v); end
        phase_run = 1'b1;
        for (int i = 1; i < 5; i++) begin
            next_slot();
            exp_v = {2'd1, 3'b100, 22'h20 + 22'(i), 8'hB0 + 8'(i), (i == 4) ? 3'b001 : 3'b101}; n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL drain_%0d got=%h want=%h", i, obs, exp_v); end
        end
        next_slot();
        exp_v = {2'd0, 3'b000, 22'h24, 8'hB4, 3'b001}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL drain_idle got=%h want=%h", obs, exp_v); end
        reset = 1'b1; #1;
        exp_v = '0; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL overflow_reset got=%h want=%h", obs, exp_v); end
        @(negedge clk);
        reset = 1'b0; downloading = 1'b0;
        $display("[TB] fifo overflow done");
    endtask

    task automatic test_cpu_ppu;
        next_slot();
        cpu_rd = 1'b1; cpu_addr = 22'h8000; ppu_rd = 1'b1; ppu_addr = 22'h0100;
        @(negedge clk);
        cpu_rd = 1'b0; ppu_rd = 1'b0;
        next_slot();
        exp_v = {2'd2, 3'b010, 22'h8000, 8'h00, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cpu_first got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd3, 3'b001, 22'h0100, 8'h00, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ppu_second got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd0, 3'b000, 22'h0100, 8'h00, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cpu_ppu_idle got=%h want=%h", obs, exp_v); end
        $display("[TB] cpu/ppu contention done");
    endtask

    task automatic test_cpu_priority;
        // Read is overwritten by a second read, and a write outranks it.
        cpu_rd = 1'b1; cpu_addr = 22'h1111; @(negedge clk);
        cpu_addr = 22'h2222; @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 22'h0300; cpu_dout = 8'h5A; @(negedge clk);
        cpu_wr = 1'b0;
        next_slot();
        exp_v = {2'd2, 3'b100, 22'h0300, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cpu_write got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd2, 3'b010, 22'h2222, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cpu_read_overwrite got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd0, 3'b000, 22'h2222, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL cpu_prio_idle got=%h want=%h", obs, exp_v); end
        // Request in the phase==3 cycle itself: command on the very next cycle.
        to_phase3();
        cpu_rd = 1'b1; cpu_addr = 22'h1234; @(negedge clk);
        cpu_rd = 1'b0;
        exp_v = {2'd2, 3'b010, 22'h1234, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL latency_min got=%h want=%h", obs, exp_v); end
        $display("[TB] cpu priority/latency done");
    endtask

    task automatic test_alternate;
        next_slot();
        cpu_rd = 1'b1; cpu_addr = 22'h4000; ppu_rd = 1'b1; ppu_addr = 22'h0200;
        for (int i = 0; i < 4; i++) begin
            next_slot();
            if (i % 2 == 0) exp_v = {2'd2, 3'b010, 22'h4000, 8'h5A, 3'b000};
            else            exp_v = {2'd3, 3'b001, 22'h0200, 8'h5A, 3'b000};
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL alternate_%0d got=%h want=%h", i, obs, exp_v); end
        end
        cpu_rd = 1'b0; ppu_rd = 1'b0;
        next_slot();
        exp_v = {2'd2, 3'b010, 22'h4000, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL alternate_tail got=%h want=%h", obs, exp_v); end
        next_slot();
        exp_v = {2'd0, 3'b000, 22'h4000, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL alternate_idle got=%h want=%h", obs, exp_v); end
        $display("[TB] alternation done");
    endtask

    task automatic test_download_hold;
        downloading = 1'b1;
        cpu_rd = 1'b1; cpu_addr = 22'h8123; @(negedge clk);
        cpu_rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_slot();
            exp_v = {2'd0, 3'b000, 22'h4000, 8'h5A, 3'b000}; n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL dl_hold_%0d got=%h want=%h", i, obs, exp_v); end
        end
        downloading = 1'b0;
        next_slot();
        exp_v = {2'd2, 3'b010, 22'h8123, 8'h5A, 3'b000}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL dl_release got=%h want=%h", obs, exp_v); end
        $display("[TB] download hold done");
    endtask

    task automatic test_reset_mid_slot;
        downloading = 1'b1;
        next_slot();
        ldr_wr = 1'b1; ldr_addr = 22'h30; ldr_data = 8'hC0; @(negedge clk);
        ldr_addr = 22'h31; ldr_data = 8'hC1; @(negedge clk);
        ldr_addr = 22'h32; ldr_data = 8'hC2; @(negedge clk);
        ldr_wr = 1'b0;
        next_slot();
        exp_v = {2'd1, 3'b100, 22'h30, 8'hC0, 3'b100}; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mid_ldr_slot got=%h want=%h", obs, exp_v); end
        @(negedge clk); #2;
        reset = 1'b1; #1;
        exp_v = '0; n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mid_reset_async got=%h want=%h", obs, exp_v); end
        @(negedge clk);
        reset = 1'b0; downloading = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_slot();
            exp_v = '0; n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset_idle_%0d got=%h want=%h", i, obs, exp_v); end
        end
        $display("[TB] mid-slot reset done");
    endtask

    initial begin
        test_reset();
        test_loader_burst();
        test_fifo_overflow();
        test_cpu_ppu();
        test_cpu_priority();
        test_alternate();
        test_download_hold();
        test_reset_mid_slot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_slot_arbiter.md
SDRAM_SLOT_ARBITER -- requirements
Module: sdram_slot_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22: width of all SDRAM byte addresses.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two: number of loader-write FIFO entries.
REQ-003 Port clk, input, 1: NES clock, rising edge only; the only clock of the block.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port phase, input, 2: free-running 0,1,2,3 slot counter, synchronous to clk.
REQ-006 Port downloading, input, 1: game download in progress.
REQ-007 Port ldr_wr, input, 1: single-cycle loader write strobe.
REQ-008 Port ldr_addr, input, ADDR_W: loader write address.
REQ-009 Port ldr_data, input, 8: loader write data.
REQ-010 Port cpu_rd, input, 1: CPU read request; may be a single-cycle pulse.
REQ-011 Port cpu_wr, input, 1: CPU write request; may be a single-cycle pulse.
REQ-012 Port cpu_addr, input, ADDR_W: CPU address.
REQ-013 Port cpu_dout, input, 8: CPU write data.
REQ-014 Port ppu_rd, input, 1: PPU read request; may be a single-cycle pulse.
REQ-015 Port ppu_addr, input, ADDR_W: PPU address.
REQ-016 Ports mem_addr (ADDR_W), mem_din (8), mem_we (1), mem_oe_a (1), mem_oe_b (1), outputs: SDRAM command, all registered.
REQ-017 Port grant, output, 2: current slot owner; 0 idle, 1 loader, 2 CPU, 3 PPU.
REQ-018 Port fifo_full, output, 1: loader FIFO holds FIFO_DEPTH entries.
REQ-019 Port busy, output, 1: loader FIFO is non-empty.
REQ-020 Port overflow, output, 1: sticky flag set when a loader write is dropped.

Function
REQ-021 Requests are latched on the cycle they are seen; one pending flag each for CPU-read, CPU-write and PPU-read, with address and data captured. A flag clears only when its request is granted.
REQ-022 A new request of a type already pending overwrites that type's captured address and data; the flag stays set.
REQ-023 The loader FIFO pushes {ldr_addr, ldr_data} on ldr_wr when not full. A push while full is dropped and sets overflow.
REQ-024 A simultaneous push and pop is accepted when the FIFO is full, because the pop is evaluated first. The FIFO count never exceeds FIFO_DEPTH and never underflows.
REQ-025 Arbitration happens only on cycles with phase==3. The chosen command is registered on that edge and held unchanged through phases 0..3, i.e. exactly 4 clk cycles.
REQ-026 The arbiter has four states: IDLE, LDR, CPU, PPU. The next state is chosen at each phase==3 edge by this priority:
 (a) FIFO non-empty -> LDR; one entry is popped; mem_we=1.
 (b) Else, if downloading=1 -> IDLE; CPU and PPU requests stay pending.
 (c) Else, if the starve bit is set and PPU is pending -> PPU.
 (d) Else, if CPU-write is pending -> CPU with mem_we=1; else if CPU-read is pending -> CPU with mem_oe_a=1.
 (e) Else, if PPU is pending -> PPU with mem_oe_b=1.
 (f) Else -> IDLE.
REQ-027 The starve bit is set when PPU is pending and CPU is granted. It is cleared when PPU is granted.
REQ-028 Only one of mem_we, mem_oe_a, mem_oe_b is active at a time. In IDLE all three are 0, and mem_addr and mem_din hold their last values.
REQ-029 When downloading falls while the FIFO is non-empty, the FIFO keeps draining; busy stays 1 until the last pop.
REQ-030 grant equals the state encoding and changes only on phase==3 edges.
REQ-031 Grant latency is at most 4 clk cycles, counted from request to command, for an uncontended request.
REQ-032 The FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-033 While reset=1, asynchronously:
 - state=IDLE and grant=0.
 - mem_we, mem_oe_a and mem_oe_b are 0.
 - mem_addr=0 and mem_din=0.
 - The FIFO is emptied, so fifo_full=0 and busy=0.
 - overflow=0, and all pending flags and the starve bit are cleared.
REQ-034 Reset asserted mid-slot aborts the command immediately. After release, the first grant occurs at the next phase==3 edge.

Verification
REQ-035 downloading=1; 3 ldr_wr pulses (addr 0x10/0x11/0x12, data 0xA0/A1/A2) -> three consecutive LDR slots, mem_we=1 and addresses in order; busy falls after the third pop.
REQ-036 5 ldr_wr in 5 consecutive cycles, FIFO_DEPTH=4, no phase==3 in between -> fifo_full=1; the 5th write is dropped; overflow=1 and stays set until reset.
REQ-037 downloading=0; cpu_rd (addr 0x8000) and ppu_rd (addr 0x0100) pulsed in the same cycle -> CPU slot (mem_oe_a=1, addr 0x8000), then PPU slot (mem_oe_b=1, addr 0x0100).
REQ-038 cpu_rd held continuously with ppu_rd pending -> grants alternate CPU, PPU, CPU, PPU; the PPU is never denied two slots in a row.
REQ-039 cpu_rd pulsed while downloading=1 with the FIFO empty -> IDLE slots. After downloading falls, the next slot is CPU, with the captured address.
REQ-040 reset pulsed during an LDR slot with 2 entries queued -> all outputs go to 0 immediately and busy=0; after release, grant stays 0 when no requests are present.
